audio_sample_sched: RTL
=======================

# audio_sample_sched

Sample scheduler for the PDM audio DAC path. It buffers 12-bit samples the CPU writes over the iomem peripheral bus in a FIFO. It pops one sample per programmable sample period into the DAC input register. Status, underrun tracking and a low-water interrupt let firmware refill the buffer without polling at sample rate. It replaces the direct audio register at iomem page 0x04, and its `audio_out` drives `pdm_dac.din`.

## Interface
- `DEPTH`, 16: FIFO depth in samples. Must be a power of two, 4..256.
- `DEFAULT_DIV`, 362: reset value of DIV. Sample period is DIV+1 clocks; 16 MHz/363 ≈ 44.1 kHz.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `sel` in 1: page decode, driven high when iomem_addr[31:24]==8'h04.
- `iomem_valid` in 1: bus request.
- `iomem_ready` out 1: one-cycle acknowledge.
- `iomem_wstrb` in 4: byte write strobes; all zero means read.
- `iomem_addr` in 8: register offset (iomem_addr[7:0]).
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data, valid while iomem_ready=1.
- `audio_out` out 12: unsigned sample to the DAC.
- `irq` out 1: low-water interrupt, level-sensitive.

## Operation
- Registers (offset: field):
  - 0x00 DATA (W): any wstrb pushes wdata[11:0]. Reads return 0.
  - 0x04 CTRL (RW): bit0 EN; bit1 FLUSH (write-1, self-clearing, reads 0); bit2 IRQ_EN.
  - 0x08 DIV (RW): bits[15:0].
  - 0x0C STATUS (R): [8:0] LEVEL; bit16 EMPTY; bit17 FULL; bit18 UNDERRUN (sticky); bit19 OVERFLOW (sticky). Writing 1 to bit18 or bit19 clears that bit.
  - 0x10 THRESH (RW): bits[8:0], low-water mark.
  - Other offsets read 0 and ignore writes.
- Bus handshake: a request is accepted when sel & iomem_valid & !iomem_ready.
  - iomem_ready is 1 for exactly the next cycle and then 0.
  - iomem_rdata is registered on the same edge.
  - Register writes take effect on the accepting edge and honour byte strobes per byte lane. DATA ignores lanes: any strobe pushes.
- Divider: 16-bit counter `cnt`.
  - With EN=1: if cnt==DIV, then cnt←0 and a tick is generated; otherwise cnt←cnt+1.
  - With EN=0: cnt←0 and no ticks.
  - A DIV write does not reset cnt. If the new DIV is below cnt, cnt runs up to 16'hFFFF, wraps to 0 and continues, and the next tick occurs once cnt reaches the new DIV.
- Tick handling:
  - FIFO non-empty: audio_out←head and pop.
  - FIFO empty: audio_out holds and UNDERRUN←1.
- Push to a full FIFO:
  - Dropped, OVERFLOW←1.
  - Exception: if a pop occurs on the same edge, the push is accepted and LEVEL stays DEPTH.
- Push to an empty FIFO coincident with a tick: UNDERRUN←1 and the sample is stored. No bypass to audio_out.
- Simultaneous push and pop: LEVEL unchanged.
- FLUSH:
  - Empties the FIFO and clears cnt.
  - Takes precedence over a same-edge tick.
  - audio_out holds; sticky flags are unaffected.
- Disabling (EN←0) holds audio_out and keeps FIFO contents.
- irq is registered: irq←IRQ_EN & EN & (LEVEL < THRESH), using post-update LEVEL.

## Timing
- Reset values:
  - iomem_ready=0, iomem_rdata=0, irq=0.
  - audio_out=12'h800 (midscale silence).
  - EN=0, IRQ_EN=0, DIV=DEFAULT_DIV, THRESH=DEPTH/2, cnt=0, FIFO empty, flags 0.
- Reset may assert mid-transfer or mid-period: all state returns to reset values immediately, with no partial push.
- Bus latency: 1 cycle from accepted request to iomem_ready.
- Enable to first tick: EN written on edge N sets cnt=0 at N. The first tick is at edge N+DIV+1, and ticks repeat every DIV+1 edges.
- audio_out changes on the tick edge.
- irq reflects a LEVEL change one cycle later.
- STATUS reads return values from before the accepting edge.

## Configuration
- `AUDIO_SCHED_IRQ_EN`:
  - Defined: IRQ_EN, THRESH and irq are implemented as above.
  - Undefined: irq is tied 0, THRESH reads 0 and ignores writes, and CTRL bit2 reads 0.

## Test plan
- Reset, then read STATUS → 0x0001_0000 (EMPTY, LEVEL=0). audio_out=0x800, irq=0.
- DIV=3; push 0x123, 0x456; EN=1 → audio_out=0x123 four clocks after the EN edge and 0x456 four clocks later. UNDERRUN sets on the third tick; writing 0x0004_0000 to STATUS clears it.
- Push DEPTH+1 samples with EN=0 → LEVEL=DEPTH, FULL=1, OVERFLOW=1. The first DEPTH values play out in order once enabled.
- THRESH=4, IRQ_EN=1, EN=1, DIV=0, push 6 samples → irq rises one cycle after LEVEL drops to 3. Pushing 2 more drops irq.
- With FIFO full, time a push on the same edge as a tick → push accepted, LEVEL stays DEPTH, OVERFLOW stays 0.
- Write FLUSH on an edge where cnt==DIV → no pop, audio_out unchanged, LEVEL=0, cnt=0. Assert reset mid-transfer → iomem_ready=0 on the next edge and all reset values restored.

Source files
------------

// File: rtl/audio_sample_sched.sv
// audio_sample_sched: iomem-mapped sample FIFO that feeds the PDM DAC input
// register at a programmable sample period (DIV+1 clocks).
// Optional build macro AUDIO_SCHED_IRQ_EN adds IRQ_EN, THRESH and the
// low-water interrupt; without it irq is tied low and those fields read 0.
module audio_sample_sched #(
    parameter int DEPTH       = 16,
    parameter int DEFAULT_DIV = 362
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [7:0]  iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic [11:0] audio_out,
    output logic        irq
);
    localparam int         AW         = $clog2(DEPTH);
    localparam logic [8:0] LVL_FULL   = 9'(DEPTH);
    localparam logic [8:0] THRESH_RST = 9'(DEPTH / 2);

    logic          r_ready;
    logic [31:0]   r_rdata;
    logic [11:0]   r_audio;
    logic          r_en;
    logic [15:0]   r_div;
    logic [15:0]   r_cnt;
    logic [11:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [8:0]    r_level;
    logic          r_underrun;
    logic          r_overflow;

    logic          w_accept, w_wr, w_rd;
    logic          w_push, w_ctrl_wr, w_div_wr, w_status_wr, w_thresh_wr;
    logic          w_flush, w_tick, w_tick_eff, w_pop, w_push_ok;
    logic          w_empty, w_full, w_under_set, w_over_set;
    logic          w_irq_en;
    logic [8:0]    w_thresh;
    logic [31:0]   w_rdmux;
    logic          w_unused;

    // A request is taken only while no acknowledge is outstanding
    assign w_accept    = sel & iomem_valid & ~r_ready;
    assign w_wr        = w_accept & (|iomem_wstrb);
    assign w_rd        = w_accept & ~(|iomem_wstrb);
    assign w_push      = w_wr & (iomem_addr == 8'h00);
    assign w_ctrl_wr   = w_wr & (iomem_addr == 8'h04) & iomem_wstrb[0];
    assign w_div_wr    = w_wr & (iomem_addr == 8'h08);
    assign w_status_wr = w_wr & (iomem_addr == 8'h0C) & iomem_wstrb[2];
    assign w_thresh_wr = w_wr & (iomem_addr == 8'h10);
    assign w_flush     = w_ctrl_wr & iomem_wdata[1];

    assign w_empty     = (r_level == 9'd0);
    assign w_full      = (r_level == LVL_FULL);
    // Flush wins over a coincident tick: nothing pops and no underrun
    assign w_tick      = r_en & (r_cnt == r_div);
    assign w_tick_eff  = w_tick & ~w_flush;
    assign w_pop       = w_tick_eff & ~w_empty;
    assign w_under_set = w_tick_eff & w_empty;
    // A full FIFO still takes a push when a pop frees a slot on the same edge
    assign w_push_ok   = w_push & (~w_full | w_pop);
    assign w_over_set  = w_push & w_full & ~w_pop;

    assign w_unused    = ^{iomem_wdata[31:20], iomem_wdata[17:16]};

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign audio_out   = r_audio;

    // Register read mux, sampled on the accepting edge (pre-update values)
    always_comb begin
        w_rdmux = '0;
        case (iomem_addr)
            8'h04:   w_rdmux = {29'd0, w_irq_en, 1'b0, r_en};
            8'h08:   w_rdmux = {16'd0, r_div};
            8'h0C:   w_rdmux = {12'd0, r_overflow, r_underrun, w_full, w_empty, 7'd0, r_level};
            8'h10:   w_rdmux = {23'd0, w_thresh};
            default: w_rdmux = '0;
        endcase
    end

    // One-cycle bus acknowledge with registered read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_accept;
            r_rdata <= w_rd ? w_rdmux : 32'd0;
        end
    end

    // CTRL.EN and DIV with per-lane byte strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en  <= 1'b0;
            r_div <= 16'(DEFAULT_DIV);
        end else begin
            if (w_ctrl_wr)
                r_en <= iomem_wdata[0];
            if (w_div_wr && iomem_wstrb[0])
                r_div[7:0] <= iomem_wdata[7:0];
            if (w_div_wr && iomem_wstrb[1])
                r_div[15:8] <= iomem_wdata[15:8];
        end
    end

    // Sample-period counter; a DIV write below cnt lets it wrap through 16'hFFFF
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (w_flush || !r_en || w_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 16'd1;
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push_ok && !w_pop)
                r_level <= r_level + 9'd1;
            else if (!w_push_ok && w_pop)
                r_level <= r_level - 9'd1;
        end
    end

    // Sample storage; contents are don't-care until the pointers cover them
    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= iomem_wdata[11:0];
    end

    // DAC input register: updates only when a tick pops a sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_audio <= 12'h800;
        else if (w_pop)
            r_audio <= r_mem[r_rd_ptr];
    end

    // Sticky flags: a new event on the same edge beats a write-1 clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_under_set)
                r_underrun <= 1'b1;
            else if (w_status_wr && iomem_wdata[18])
                r_underrun <= 1'b0;
            if (w_over_set)
                r_overflow <= 1'b1;
            else if (w_status_wr && iomem_wdata[19])
                r_overflow <= 1'b0;
        end
    end

`ifdef AUDIO_SCHED_IRQ_EN
    logic       r_irq_en;
    logic [8:0] r_thresh;
    logic       r_irq;

    // IRQ_EN/THRESH and the low-water interrupt, one cycle behind LEVEL
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_en <= 1'b0;
            r_thresh <= THRESH_RST;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr)
                r_irq_en <= iomem_wdata[2];
            if (w_thresh_wr && iomem_wstrb[0])
                r_thresh[7:0] <= iomem_wdata[7:0];
            if (w_thresh_wr && iomem_wstrb[1])
                r_thresh[8] <= iomem_wdata[8];
            r_irq <= r_irq_en & r_en & (r_level < r_thresh);
        end
    end

    assign w_irq_en = r_irq_en;
    assign w_thresh = r_thresh;
    assign irq      = r_irq;
`else
    logic w_unused_thresh;
    assign w_unused_thresh = w_thresh_wr ^ (|THRESH_RST);
    assign w_irq_en = 1'b0;
    assign w_thresh = '0;
    assign irq      = 1'b0;
`endif

endmodule
